// File: rtl/accum_pkg.sv
// Shared definitions for the accumulator unit: datapath width, op codes and FSM states.
package accum_pkg;

  localparam int WIDTH = 16;

  typedef enum logic [2:0] {
    OP_LOAD = 3'b000,
    OP_ADD  = 3'b001,
    OP_SUB  = 3'b010,
    OP_AND  = 3'b011,
    OP_OR   = 3'b100,
    OP_XOR  = 3'b101,
    OP_MUL  = 3'b110,
    OP_CLR  = 3'b111
  } op_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/mul_seq.sv
// Sequential shift-add unsigned multiplier, one multiplier bit per clock, LSB first.
// done and product are combinational on the final step so the caller can latch on that edge.
module mul_seq #(
  parameter int WIDTH = accum_pkg::WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   mcand,
  input  logic [WIDTH-1:0]   mplier,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);

  logic                 running;
  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0]   prod_q;
  logic [WIDTH-1:0]     mplier_q;
  logic [2*WIDTH-1:0]   partial;

  assign partial = mplier_q[0] ? mcand_q : '0;
  assign product = prod_q + partial;
  assign done    = running && (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      running <= 1'b0;
      cnt     <= '0;
    end else if (start) begin
      running <= 1'b1;
      cnt     <= '0;
    end else if (running) begin
      cnt <= cnt + CW'(1);
      if (done) running <= 1'b0;
    end
  end

  // Data registers carry no reset; running gates every use of them.
  always_ff @(posedge clk) begin
    if (start) begin
      mcand_q  <= {{WIDTH{1'b0}}, mcand};
      mplier_q <= mplier;
      prod_q   <= '0;
    end else if (running) begin
      prod_q   <= product;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
    end
  end

endmodule

// File: rtl/accum_unit.sv
// Accumulator with single-cycle ALU ops and a 16-cycle shift-add multiply.
// Flags and acc update together; done pulses the cycle after a result lands.
module accum_unit #(
  parameter int WIDTH = accum_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic [2:0]       op,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] acc_out,
  output logic             done,
  output logic             busy,
  output logic             zero,
  output logic             carry,
  output logic             ovf
);

  import accum_pkg::*;

  state_t               state;
  logic                 accept;
  logic                 accept_mul;
  logic [WIDTH:0]       ext;
  logic [WIDTH-1:0]     alu_res;
  logic                 alu_carry;
  logic                 alu_ovf;
  logic                 mul_done;
  logic [2*WIDTH-1:0]   mul_prod;

  function automatic logic add_ovf(input logic signed [WIDTH-1:0] a,
                                   input logic signed [WIDTH-1:0] b,
                                   input logic signed [WIDTH-1:0] s);
    return ((a < 0) == (b < 0)) && ((s < 0) != (a < 0));
  endfunction

  function automatic logic sub_ovf(input logic signed [WIDTH-1:0] a,
                                   input logic signed [WIDTH-1:0] b,
                                   input logic signed [WIDTH-1:0] d);
    return ((a < 0) != (b < 0)) && ((d < 0) != (a < 0));
  endfunction

  assign in_ready   = (state == ST_IDLE);
  assign busy       = (state == ST_MUL);
  assign accept     = in_valid && in_ready;
  assign accept_mul = accept && (op_t'(op) == OP_MUL);

  always_comb begin
    ext       = '0;
    alu_res   = acc_out;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    case (op_t'(op))
      OP_LOAD: alu_res = in_data;
      OP_ADD: begin
        ext       = {1'b0, acc_out} + {1'b0, in_data};
        alu_res   = ext[WIDTH-1:0];
        alu_carry = ext[WIDTH];
        alu_ovf   = add_ovf(acc_out, in_data, ext[WIDTH-1:0]);
      end
      // The extra bit of the widened difference is the unsigned borrow.
      OP_SUB: begin
        ext       = {1'b0, acc_out} - {1'b0, in_data};
        alu_res   = ext[WIDTH-1:0];
        alu_carry = ext[WIDTH];
        alu_ovf   = sub_ovf(acc_out, in_data, ext[WIDTH-1:0]);
      end
      OP_AND:  alu_res = acc_out & in_data;
      OP_OR:   alu_res = acc_out | in_data;
      OP_XOR:  alu_res = acc_out ^ in_data;
      OP_CLR:  alu_res = '0;
      default: alu_res = acc_out;
    endcase
  end

  mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (accept_mul),
    .mcand   (acc_out),
    .mplier  (in_data),
    .done    (mul_done),
    .product (mul_prod)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      acc_out <= '0;
      zero    <= 1'b0;
      carry   <= 1'b0;
      ovf     <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept_mul) begin
            state <= ST_MUL;
          end else if (accept) begin
            acc_out <= alu_res;
            zero    <= (alu_res == '0);
            carry   <= alu_carry;
            ovf     <= alu_ovf;
            done    <= 1'b1;
          end
        end
        ST_MUL: begin
          if (mul_done) begin
            state   <= ST_IDLE;
            acc_out <= mul_prod[WIDTH-1:0];
            zero    <= (mul_prod[WIDTH-1:0] == '0);
            carry   <= |mul_prod[2*WIDTH-1:WIDTH];
            ovf     <= 1'b0;
            done    <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/accum_unit.md
ACCUM_UNIT -- requirements
Module: accum_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, named clk and rst.
REQ-002 WIDTH, default 16: datapath width of operand, accumulator and result.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 in_data  input  WIDTH  operand, driven by the upstream 2:1 operand multiplexer output.
REQ-006 op  input  3  operation code, sampled only when an operand is accepted.
REQ-007 in_valid  input  1  operand and op are valid this cycle.
REQ-008 in_ready  output  1  block can accept an operand this cycle.
REQ-009 acc_out  output  WIDTH  accumulator value, registered.
REQ-010 done  output  1  one-cycle pulse when acc_out and flags reflect a completed operation.
REQ-011 busy  output  1  high while a multi-cycle operation is in progress.
REQ-012 zero, carry, ovf  output  1 each  result flags, registered.

Function
REQ-013 An operand SHALL be accepted on a rising edge where in_valid and in_ready are both 1; in_ready SHALL be 1 exactly in state IDLE.
REQ-014 States SHALL be IDLE and MUL; IDLE->MUL on accept with op=MUL; MUL->IDLE after 16 MUL cycles; every other accept stays in IDLE.
REQ-015 op encoding: 000 LOAD, 001 ADD, 010 SUB, 011 AND, 100 OR, 101 XOR, 110 MUL, 111 CLR.
REQ-016 LOAD: acc=in_data. CLR: acc=0, in_data ignored. AND/OR/XOR: acc=acc op in_data.
REQ-017 ADD: acc=(acc+in_data) mod 2^WIDTH; carry=unsigned carry-out; ovf=signed two's-complement overflow.
REQ-018 SUB: acc=(acc-in_data) mod 2^WIDTH; carry=1 when acc<in_data unsigned (borrow); ovf=signed overflow.
REQ-019 LOAD, CLR, AND, OR and XOR SHALL clear carry and ovf.
REQ-020 MUL: shift-add, one multiplier bit per cycle, LSB first; acc=low WIDTH bits of the unsigned product; carry=1 when the upper WIDTH product bits are nonzero; ovf=0.
REQ-021 zero SHALL equal (new acc == 0) for every operation and update together with acc.
REQ-022 Single-cycle ops: acc, flags and done SHALL update on the accept edge, so done is high for the cycle after accept (latency 1).
REQ-023 MUL: acc, flags and done SHALL update on the 16th clock edge after the accept edge; until then acc_out and flags hold their pre-MUL values.
REQ-024 busy SHALL be 1 exactly while in state MUL; done SHALL never be high for more than one consecutive cycle except for back-to-back single-cycle accepts.
REQ-025 in_valid, op and in_data SHALL be ignored while busy; the multiplicand and multiplier SHALL be captured internally at accept.
REQ-026 Back-to-back single-cycle accepts SHALL be supported at one per cycle, each using the acc produced by the previous one.
REQ-027 A MUL accept followed immediately by in_valid=1 SHALL accept the next operand on the first edge after MUL->IDLE, not earlier.

Reset
REQ-028 rst SHALL immediately force state=IDLE and acc_out, zero, carry, ovf, done, busy to 0, and in_ready to 1, independent of clk.
REQ-029 rst asserted mid-MUL SHALL abort the multiply with no partial result visible after release.
REQ-030 The first accept SHALL be possible on the first rising edge after rst deasserts.

Structure
REQ-031 A shared package accum_pkg SHALL hold WIDTH, the op enum (op_t) and the state enum (state_t).
REQ-032 The shift-add multiplier SHALL be a sub-module mul_seq with start/operands in and done/product out; everything else lives in accum_unit.

Verification
REQ-033 LOAD 0x7FFF then ADD 0x0001 -> acc_out=0x8000, carry=0, ovf=1, zero=0, done pulses 1 cycle after each accept.
REQ-034 LOAD 0x0003 then SUB 0x0005 -> acc_out=0xFFFE, carry=1, ovf=0; then ADD 0x0002 -> acc_out=0x0000, zero=1, carry=1.
REQ-035 LOAD 0x0100 then MUL 0x0100 -> in_ready=0 and busy=1 for 16 cycles, then acc_out=0x0000, carry=1, zero=1, done pulses once.
REQ-036 LOAD 0x00FF, MUL 0x0003 with in_valid held high (op=ADD, 0x0001) during MUL -> acc_out=0x02FD after MUL, then 0x02FE; no operand accepted while busy.
REQ-037 Assert rst 5 cycles into MUL -> all outputs 0, in_ready=1 immediately; LOAD 0x1234 after release -> acc_out=0x1234.
REQ-038 XOR 0xFFFF after ADD produced carry=1 -> carry=0, ovf=0, acc_out=bitwise inverse of prior acc.
